// File: rtl/span_rasterizer_if.sv
// Span input and pixel FIFO output bundle for the span rasterizer.
// The slave side is the rasterizer itself: it receives spans and drives
// the FIFO write port. The master side is the surrounding environment.
// Vectors use big-endian numbering (bit 0 = MSB), matching the FIFO layout.
interface span_rasterizer_if #(
    parameter int RAST_FBW_FIFO_LEN = 96,
    parameter int LINE_LEN          = 9,
    parameter int COL_LEN           = 10
);
    logic                         span_valid;
    logic                         span_ready;
    logic [0:LINE_LEN-1]          span_line;
    logic [0:COL_LEN-1]           span_x0;
    logic [0:COL_LEN-1]           span_x1;
    logic [0:31]                  span_color;
    logic [0:RAST_FBW_FIFO_LEN-1] fifo_din;
    logic                         fifo_wr_en;
    logic                         fifo_full;

    modport master (
        output span_valid, span_line, span_x0, span_x1, span_color, fifo_full,
        input  span_ready, fifo_din, fifo_wr_en
    );

    modport slave (
        input  span_valid, span_line, span_x0, span_x1, span_color, fifo_full,
        output span_ready, fifo_din, fifo_wr_en
    );
endinterface

// File: rtl/span_rasterizer.sv
// Span rasterizer: turns horizontal span descriptors into one FIFO pixel
// word per cycle. Spans are clipped to the right screen edge; spans that
// lie below the screen or are empty after clipping are dropped. Writes
// stall while the downstream FIFO reports full.
module span_rasterizer #(
    parameter int RAST_FBW_FIFO_LEN = 96,
    parameter int LINE_LEN          = 9,
    parameter int COL_LEN           = 10,
    parameter int SCREEN_W          = 640,
    parameter int SCREEN_H          = 480
) (
    input  logic                PLB_clk,
    input  logic                reset,
    span_rasterizer_if.slave    bus,
    output logic                busy,
    output logic [0:31]         pix_count,
    output logic [0:1]          state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [COL_LEN-1:0]  LAST_COL   = COL_LEN'(SCREEN_W - 1);
    localparam logic [LINE_LEN-1:0] LINE_LIMIT = LINE_LEN'(SCREEN_H);

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic [LINE_LEN-1:0]          line_r;
    logic [COL_LEN-1:0]           col_r;
    logic [COL_LEN-1:0]           end_r;
    logic [31:0]                  color_r;
    logic [31:0]                  pix_count_r;
    logic                         accept_s;
    logic                         wr_en_s;
    logic                         drop_s;
    logic [COL_LEN-1:0]           x1c_s;
    logic [0:RAST_FBW_FIFO_LEN-1] word_s;

    // Clamp the inclusive end column to the last visible column.
    function automatic logic [COL_LEN-1:0] clip_end(input logic [COL_LEN-1:0] x1);
        if (x1 > LAST_COL) begin
            return LAST_COL;
        end else begin
            return x1;
        end
    endfunction

    // Next-state, accept and write-strobe decode; reset suppresses everything.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        wr_en_s     = 1'b0;
        x1c_s       = clip_end(bus.span_x1);
        drop_s      = (bus.span_line >= LINE_LIMIT) || (bus.span_x0 > x1c_s);
        if (reset) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.span_valid) begin
                        accept_s    = 1'b1;
                        state_nxt_s = drop_s ? DROP : EMIT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                EMIT: begin
                    if (!bus.fifo_full) begin
                        wr_en_s = 1'b1;
                        if (col_r == end_r) begin
                            state_nxt_s = IDLE;
                        end else begin
                            state_nxt_s = EMIT;
                        end
                    end else begin
                        state_nxt_s = EMIT;
                    end
                end
                DROP: begin
                    state_nxt_s = IDLE;
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Span registers: loaded on accept, column advances on each write.
    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            line_r  <= '0;
            col_r   <= '0;
            end_r   <= '0;
            color_r <= 32'd0;
        end else if (accept_s) begin
            line_r  <= bus.span_line;
            col_r   <= bus.span_x0;
            end_r   <= x1c_s;
            color_r <= bus.span_color;
        end else if (wr_en_s && (col_r != end_r)) begin
            col_r   <= col_r + COL_LEN'(1);
        end else begin
            col_r   <= col_r;
        end
    end

    // Running count of pixels written since reset, wrapping at 2^32.
    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            pix_count_r <= 32'd0;
        end else if (wr_en_s) begin
            pix_count_r <= pix_count_r + 32'd1;
        end else begin
            pix_count_r <= pix_count_r;
        end
    end

    // FIFO word: zero-extended line, zero-extended column, colour, zero pad.
    assign word_s = {{(16 - LINE_LEN){1'b0}}, line_r,
                     {(16 - COL_LEN){1'b0}}, col_r,
                     color_r,
                     32'd0};

    assign bus.fifo_din   = word_s;
    assign bus.fifo_wr_en = wr_en_s;
    assign bus.span_ready = (state_r == IDLE);
    assign busy           = (state_r != IDLE);
    assign pix_count      = pix_count_r;
    assign state          = state_r;

endmodule

// File: tb/tb_span_rasterizer.sv
// Scoreboard bench for span_rasterizer: a span-level reference model pushes
// every expected pixel word, and a monitor pops/compares on each FIFO write.
module tb_span_rasterizer;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [0:31] pix_count;
    logic [0:1]  state;

    span_rasterizer_if bus ();

    span_rasterizer dut (
        .PLB_clk   (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .busy      (busy),
        .pix_count (pix_count),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int           tests = 0;
    int           fails = 0;
    logic [95:0]  exp_q[$];
    int unsigned  exp_pix = 0;
    int           wr_total = 0;
    int           first_wr = -1;
    int           last_wr = -1;
    logic [95:0]  held_din;
    bit           have_held = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: clip to screen, drop empty or off-screen spans.
    task automatic model_span(input int l, input int x0, input int x1, input logic [31:0] c);
        int hi;
        logic [95:0] w;
        hi = (x1 > 639) ? 639 : x1;
        if (l < 480 && x0 <= hi) begin
            for (int x = x0; x <= hi; x++) begin
                w = {16'(l), 16'(x), c, 32'd0};
                exp_q.push_back(w);
                exp_pix++;
            end
        end
    endtask

    // Present a span; returns one cycle after the accepting edge (+1).
    task automatic send_span(input int l, input int x0, input int x1, input logic [31:0] c,
                             input bit keep_valid, output int acc);
        int t;
        model_span(l, x0, x1, c);
        bus.span_valid = 1'b1;
        bus.span_line  = 9'(l);
        bus.span_x0    = 10'(x0);
        bus.span_x1    = 10'(x1);
        bus.span_color = c;
        t = 0;
        while (bus.span_ready !== 1'b1 && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) check("accept_timeout", 96'd1, 96'd0);
        acc = cyc;
        @(posedge clk); #1;
        if (!keep_valid) bus.span_valid = 1'b0;
    endtask

    // Run until all expected pixels are written and the block is idle again.
    task automatic wait_done(input bit rand_full);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && bus.span_ready === 1'b1) && t < 5000) begin
            bus.fifo_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            t++;
        end
        bus.fifo_full = 1'b0;
        if (t >= 5000) check("done_timeout", 96'd1, 96'd0);
        check("queue_drained", 96'(exp_q.size()), 96'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_pix = 0;
    endtask

    initial begin
        int acc0, acc1, acc2, w0, l, x0, x1;
        logic [31:0] c;

        reset          = 1'b1;
        bus.span_valid = 1'b0;
        bus.span_line  = '0;
        bus.span_x0    = '0;
        bus.span_x1    = '0;
        bus.span_color = '0;
        bus.fifo_full  = 1'b0;

        // Monitor: scoreboard compare on every FIFO write, hold check on stalls.
        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    have_held = 0;
                end else if (bus.fifo_wr_en) begin
                    check("wr_while_full", 96'(bus.fifo_full), 96'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", bus.fifo_din, 96'd0 - 96'd1);
                    end else begin
                        check("pixel_word", bus.fifo_din, exp_q.pop_front());
                    end
                    if (have_held) check("din_after_stall", bus.fifo_din, held_din);
                    have_held = 0;
                    if (first_wr < 0) first_wr = cyc;
                    last_wr = cyc;
                    wr_total++;
                end else if (bus.fifo_full && state == 2'd1) begin
                    if (have_held) check("din_hold_full", bus.fifo_din, held_din);
                    held_din  = bus.fifo_din;
                    have_held = 1;
                end
            end
        join_none

        do_reset();
        check("rst_ready", 96'(bus.span_ready), 96'd1);
        check("rst_wr_en", 96'(bus.fifo_wr_en), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_pix", 96'(pix_count), 96'd0);
        check("rst_state", 96'(state), 96'd0);
        check("rst_din", bus.fifo_din, 96'd0);

        // Basic span: 4 consecutive writes, ready the cycle after the last one.
        first_wr = -1;
        send_span(5, 10, 13, 32'hDEADBEEF, 1'b0, acc0);
        wait_done(1'b0);
        check("basic_first_lat", 96'(first_wr - acc0), 96'd1);
        check("basic_last_lat", 96'(last_wr - acc0), 96'd4);
        check("basic_pix", 96'(pix_count), 96'd4);

        // Single pixel at origin, then reversed span dropped.
        send_span(0, 0, 0, 32'hDEADBEEF, 1'b0, acc0);
        wait_done(1'b0);
        w0 = wr_total;
        send_span(3, 20, 19, 32'h12345678, 1'b0, acc0);
        check("drop_ready_low", 96'(bus.span_ready), 96'd0);
        check("drop_state", 96'(state), 96'd2);
        @(posedge clk); #1;
        check("drop_ready_back", 96'(bus.span_ready), 96'd1);
        check("drop_no_writes", 96'(wr_total - w0), 96'd0);

        // Clipping at the right edge, and off-screen line / column.
        send_span(479, 636, 1000, 32'hA5A5A5A5, 1'b0, acc0);
        wait_done(1'b0);
        w0 = wr_total;
        send_span(480, 0, 5, 32'h11111111, 1'b0, acc0);
        wait_done(1'b0);
        send_span(479, 700, 800, 32'h22222222, 1'b0, acc0);
        wait_done(1'b0);
        check("offscreen_no_writes", 96'(wr_total - w0), 96'd0);
        check("clip_pix", 96'(pix_count), 96'(exp_pix));

        // Back-pressure: alternate full, then a 10-cycle full stall.
        do_reset();
        w0 = wr_total;
        send_span(100, 50, 57, 32'hCAFEF00D, 1'b0, acc0);
        for (int i = 0; i < 15; i++) begin
            bus.fifo_full = (i < 5) ? ((i % 2 == 0) ? 1'b1 : 1'b0) : 1'b1;
            @(posedge clk); #1;
        end
        bus.fifo_full = 1'b0;
        wait_done(1'b0);
        check("bp_writes", 96'(wr_total - w0), 96'd8);
        check("bp_pix", 96'(pix_count), 96'd8);

        // Reset after the 30th write of a 100-pixel span.
        w0 = wr_total;
        send_span(7, 100, 199, 32'h0BADC0DE, 1'b0, acc0);
        for (int t = 0; t < 500 && wr_total < w0 + 30; t++) begin
            @(posedge clk); #1;
        end
        check("mid_reached_30", 96'(wr_total - w0), 96'd30);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_wr_en", 96'(bus.fifo_wr_en), 96'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_pix = 0;
        check("mid_state", 96'(state), 96'd0);
        check("mid_pix", 96'(pix_count), 96'd0);
        check("mid_ready", 96'(bus.span_ready), 96'd1);
        check("mid_after_wr_en", 96'(bus.fifo_wr_en), 96'd0);
        w0 = wr_total;
        send_span(8, 300, 302, 32'h55AA55AA, 1'b0, acc0);
        wait_done(1'b0);
        check("mid_new_writes", 96'(wr_total - w0), 96'd3);

        // Back-to-back spans with span_valid held high.
        w0 = wr_total;
        send_span(10, 0, 1, 32'h01010101, 1'b1, acc0);
        send_span(11, 2, 3, 32'h02020202, 1'b1, acc1);
        send_span(12, 4, 5, 32'h03030303, 1'b0, acc2);
        wait_done(1'b0);
        check("b2b_acc1", 96'(acc1 - acc0), 96'd3);
        check("b2b_acc2", 96'(acc2 - acc1), 96'd3);
        check("b2b_writes", 96'(wr_total - w0), 96'd6);
        check("b2b_span_cycles", 96'(last_wr - acc0 + 1), 96'd9);

        // Randomized spans under random back-pressure.
        for (int n = 0; n < 30; n++) begin
            l  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 511)) : int'($urandom_range(0, 479));
            x0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(600, 1023)) : int'($urandom_range(0, 639));
            case ($urandom_range(0, 3))
                0:       x1 = int'($urandom_range(0, 1023));
                1:       x1 = (x0 > 2) ? x0 - 2 : x0;
                default: x1 = (x0 + int'($urandom_range(0, 24)) > 1023) ? 1023 : x0 + int'($urandom_range(0, 24));
            endcase
            c = $urandom;
            send_span(l, x0, x1, c, 1'b0, acc0);
            wait_done(1'b1);
        end
        check("rand_pix", 96'(pix_count), 96'(exp_pix));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/span_rasterizer.md
Name: span_rasterizer

Overview:
- Upstream neighbour of the framebuffer writer.
- Accepts horizontal spans (one screen line, start column, end column, 32-bit colour) from the triangle setup/edge-walk stage.
- Emits one 96-bit pixel entry per cycle into the rasterizer-to-framebuffer-writer FIFO.
- Clips spans to the screen, drops empty or off-screen spans, and honours FIFO back-pressure.

Parameters:
- RAST_FBW_FIFO_LEN, 96, FIFO word width in bits.
- LINE_LEN, 9, line (y) field width.
- COL_LEN, 10, column (x) field width.
- SCREEN_W, 640, visible columns; valid col is 0..SCREEN_W-1.
- SCREEN_H, 480, visible lines; valid line is 0..SCREEN_H-1.

Ports:
- PLB_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- span_valid  in  1  span descriptor valid.
- span_ready  out  1  block can accept a span.
- span_line  in  [0:LINE_LEN-1]  span y.
- span_x0  in  [0:COL_LEN-1]  first column, inclusive.
- span_x1  in  [0:COL_LEN-1]  last column, inclusive.
- span_color  in  [0:31]  pixel colour.
- fifo_din  out  [0:RAST_FBW_FIFO_LEN-1]  FIFO write data.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- busy  out  1  span in progress (state != IDLE).
- pix_count  out  [0:31]  total pixels written since reset, wraps modulo 2^32.
- state  out  [0:1]  current FSM state, for development.

Behaviour:
- Reset (sync, takes priority in every state):
  - state=IDLE, span_ready=1, fifo_wr_en=0, busy=0, pix_count=0.
  - Internal line/col/end/colour registers cleared, so fifo_din=0.
  - A span in flight is abandoned; no further writes occur.
- FIFO word layout (big-endian bit numbering, bit 0 = MSB):
  - [0:15] line, zero-extended: line in bits [16-LINE_LEN:15].
  - [16:31] column, zero-extended: col in bits [32-COL_LEN:31].
  - [32:63] colour.
  - [64:95] zero.
- States: IDLE=0, EMIT=1, DROP=2.
- IDLE:
  - span_ready=1.
  - On span_valid && span_ready, latch line, x0, x1 and colour.
  - Clipped end: x1c = min(span_x1, SCREEN_W-1).
  - Go to DROP if span_line >= SCREEN_H, or span_x0 > x1c (this covers x0 >= SCREEN_W and x0 > x1).
  - Otherwise go to EMIT with col=x0, end=x1c.
- EMIT:
  - span_ready=0.
  - fifo_wr_en = (state==EMIT) && !fifo_full, combinational; fifo_din is driven from registers and is stable while full is high.
  - On each write cycle: if col==end, go to IDLE; else col increments by 1.
  - When fifo_full=1: hold col and state; no write.
- DROP: span_ready=0 for one cycle, then IDLE. No writes.
- Span timing:
  - Span of N pixels with no back-pressure: accept cycle, then N consecutive write cycles, then span_ready=1 the cycle after the last write.
  - Minimum span period is N+1 cycles.
- pix_count increments by 1 on every cycle with fifo_wr_en=1.
- span_ready=0 in EMIT and DROP, so span_valid is ignored there; the upstream stage holds its descriptor.
- fifo_full toggling every cycle: writes occur only in cycles where it is low; no pixel is duplicated or skipped.
- Comparisons are unsigned. col never exceeds SCREEN_W-1, so there is no wrap of the COL_LEN field.

Test Plan:
- Basic span: line=5, x0=10, x1=13, colour=0xDEADBEEF, fifo_full=0 -> 4 consecutive writes with fifo_din[0:15]=0x0005, [16:31]=0x000A..0x000D, [32:63]=0xDEADBEEF, [64:95]=0; span_ready=1 the cycle after the 4th write; pix_count=4.
- Single pixel and reversed span: x0=x1=0 on line 0 -> exactly one write, word 0x0000_0000_DEADBEEF_00000000 (colour as given). Then x0=20, x1=19 -> DROP, zero writes, span_ready high again 2 cycles after accept.
- Clipping: line=479, x0=636, x1=1000 -> 4 writes, cols 636..639. Then line=480, x0=0, x1=5 -> zero writes. Then x0=700 -> zero writes.
- Back-pressure: span of 8 pixels with fifo_full asserted on alternate cycles, then held high for 10 cycles mid-span -> exactly 8 writes in order, cols strictly ascending by 1, fifo_din unchanged while full; pix_count=8.
- Reset mid-span: 100-pixel span, reset asserted for 1 cycle after the 30th write -> fifo_wr_en=0 in the reset cycle and after, state=IDLE, pix_count=0, span_ready=1. A new span of 3 pixels then produces 3 writes.
- Back-to-back spans: span_valid held high with 3 queued spans of 2 pixels each -> each accepted in the cycle after the previous span's last write; 6 writes total; 9 cycles from the first accept to the last write.
